// File: rtl/wr_b_fc_otfmap.sv
// Writes one OCH_T-element output-feature-map chunk into the packed 4x8-bit output BRAM.
// Partial edge words are read-modify-written so neighbouring elements survive.
module wr_b_fc_otfmap #(
  parameter int OCH    = 120,
  parameter int OCH_B  = 12,
  parameter int O_F_BW = 8,
  localparam int OCH_T = OCH / OCH_B,
  localparam int IDX_W = $clog2(OCH),
  localparam int AW    = $clog2((OCH + 3) / 4)
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      i_run,
  input  logic [IDX_W-1:0]          i_wr_start_idx,
  input  logic [OCH_T*O_F_BW-1:0]   i_otfmap,
  output logic                      o_idle,
  output logic                      o_run,
  output logic                      o_en_err,
  output logic                      o_ot_done,
  output logic [AW-1:0]             b_o_otfmap_addr,
  output logic                      b_o_otfmap_ce,
  output logic                      b_o_otfmap_we,
  output logic [31:0]               b_o_otfmap_d,
  input  logic [31:0]               b_i_otfmap_q
);

  localparam int EW = $clog2(OCH_T);
  localparam int PW = EW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, last_q;
  logic [1:0]          col_q, end_q;
  logic [PW-1:0]       ptr_q;
  logic                first_q;
  logic                err_q;
  logic [O_F_BW-1:0]   elem_q [OCH_T];

  logic                ready, in_range, accept, start_rd;
  logic [IDX_W-1:0]    end_idx;
  logic [AW-1:0]       start_addr, end_addr;
  logic                is_last, next_last;

  assign ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign in_range   = (int'(i_wr_start_idx) + OCH_T) <= OCH;
  assign accept     = i_run && ready && in_range;
  assign end_idx    = i_wr_start_idx + IDX_W'(OCH_T - 1);
  assign start_addr = AW'(i_wr_start_idx >> 2);
  assign end_addr   = AW'(end_idx >> 2);
  // A single-word chunk still needs a read if its trailing lanes are uncovered.
  assign start_rd   = (i_wr_start_idx[1:0] != 2'd0) ||
                      ((start_addr == end_addr) && (end_idx[1:0] != 2'd3));
  assign is_last    = (addr_q == last_q);
  assign next_last  = ((addr_q + AW'(1)) == last_q);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      col_q   <= '0;
      end_q   <= '0;
      ptr_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < OCH_T; k++) elem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (i_run && (o_run || (ready && !in_range))) err_q <= 1'b1;
      if (accept) begin
        addr_q  <= start_addr;
        last_q  <= end_addr;
        col_q   <= i_wr_start_idx[1:0];
        end_q   <= end_idx[1:0];
        ptr_q   <= '0;
        first_q <= 1'b1;
        for (int unsigned k = 0; k < OCH_T; k++)
          elem_q[k] <= i_otfmap[k*O_F_BW +: O_F_BW];
      end else if (state_q == S_WR && !is_last) begin
        addr_q  <= addr_q + AW'(1);
        ptr_q   <= ptr_q + (first_q ? (PW'(4) - PW'(col_q)) : PW'(4));
        first_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = start_rd ? S_RD : S_WR;
        else        state_d = S_IDLE;
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        if (is_last)                          state_d = S_DONE;
        else if (next_last && end_q != 2'd3)  state_d = S_RD;
        else                                  state_d = S_WR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [1:0]    lo, hi;
    logic [PW-1:0] eidx;
    o_idle          = ready;
    o_run           = !ready;
    o_en_err        = err_q;
    o_ot_done       = (state_q == S_DONE);
    b_o_otfmap_addr = '0;
    b_o_otfmap_ce   = 1'b0;
    b_o_otfmap_we   = 1'b0;
    b_o_otfmap_d    = '0;
    lo              = first_q ? col_q : 2'd0;
    hi              = is_last ? end_q : 2'd3;
    eidx            = '0;
    unique case (state_q)
      S_RD: begin
        b_o_otfmap_addr = addr_q;
        b_o_otfmap_ce   = 1'b1;
      end
      S_WR: begin
        b_o_otfmap_addr = addr_q;
        b_o_otfmap_ce   = 1'b1;
        b_o_otfmap_we   = 1'b1;
        // Covered lanes [lo,hi] map to consecutive elements starting at ptr_q.
        for (int unsigned l = 0; l < 4; l++) begin
          b_o_otfmap_d[l*O_F_BW +: O_F_BW] = b_i_otfmap_q[l*O_F_BW +: O_F_BW];
          if (2'(l) >= lo && 2'(l) <= hi) begin
            eidx = ptr_q + PW'(l) - PW'(lo);
            b_o_otfmap_d[l*O_F_BW +: O_F_BW] = elem_q[eidx[EW-1:0]];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wr_b_fc_otfmap.sv
// Directed bench for wr_b_fc_otfmap with a synchronous BRAM model.
module tb_wr_b_fc_otfmap;

  logic        clk = 1'b0;
  logic        areset;
  logic        i_run;
  logic [6:0]  i_wr_start_idx;
  logic [79:0] i_otfmap;
  logic        o_idle, o_run, o_en_err, o_ot_done;
  logic [4:0]  b_o_otfmap_addr;
  logic        b_o_otfmap_ce, b_o_otfmap_we;
  logic [31:0] b_o_otfmap_d;
  logic [31:0] b_i_otfmap_q;

  logic [31:0] mem [32];
  logic        preset;
  int          rd_cnt, wr_cnt, done_cnt;
  int          acc_cnt [32];
  int          checks, failures;

  wr_b_fc_otfmap #(.OCH(120), .OCH_B(12), .O_F_BW(8)) dut (
    .clk(clk), .areset(areset), .i_run(i_run), .i_wr_start_idx(i_wr_start_idx),
    .i_otfmap(i_otfmap), .o_idle(o_idle), .o_run(o_run), .o_en_err(o_en_err),
    .o_ot_done(o_ot_done), .b_o_otfmap_addr(b_o_otfmap_addr),
    .b_o_otfmap_ce(b_o_otfmap_ce), .b_o_otfmap_we(b_o_otfmap_we),
    .b_o_otfmap_d(b_o_otfmap_d), .b_i_otfmap_q(b_i_otfmap_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hAAAAAAAA;
    end else if (b_o_otfmap_ce) begin
      acc_cnt[b_o_otfmap_addr] <= acc_cnt[b_o_otfmap_addr] + 1;
      if (b_o_otfmap_we) begin
        mem[b_o_otfmap_addr] <= b_o_otfmap_d;
        wr_cnt <= wr_cnt + 1;
      end else begin
        b_i_otfmap_q <= mem[b_o_otfmap_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (o_ot_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk_data(input logic [7:0] base);
    logic [79:0] d;
    d = '0;
    for (int k = 0; k < 10; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic do_preset();
    @(negedge clk); preset = 1'b1;
    @(negedge clk); preset = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); areset = 1'b1;
    @(negedge clk); areset = 1'b0;
  endtask

  // Returns the cycle (1 = cycle after i_run) in which o_ot_done is seen, bounded.
  task automatic run_op(input logic [6:0] idx, input logic [79:0] data, output int cyc);
    @(negedge clk);
    i_run = 1'b1; i_wr_start_idx = idx; i_otfmap = data;
    @(negedge clk);
    i_run = 1'b0;
    cyc = 1;
    while (!o_ot_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, rd0, wr0, dn0, a30, a10;
    logic run_seen;
    checks = 0; failures = 0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 32; i++) begin acc_cnt[i] = 0; mem[i] = '0; end
    b_i_otfmap_q = '0;
    preset = 1'b0; areset = 1'b1; i_run = 1'b0; i_wr_start_idx = '0; i_otfmap = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_idle", 32'(o_idle), 32'd1);
    check_eq("rst_run", 32'(o_run), 32'd0);
    check_eq("rst_err", 32'(o_en_err), 32'd0);
    check_eq("rst_done", 32'(o_ot_done), 32'd0);
    check_eq("rst_bram", {b_o_otfmap_d[26:0], b_o_otfmap_addr}, 32'd0);
    check_eq("rst_cewe", {30'd0, b_o_otfmap_ce, b_o_otfmap_we}, 32'd0);
    areset = 1'b0;

    // start=0: two full words, then a partial last word
    do_preset();
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    i_run = 1'b1; i_wr_start_idx = 7'd0; i_otfmap = mk_data(8'h01);
    @(negedge clk);
    i_run = 1'b0;
    check_eq("t1_c1_we", 32'(b_o_otfmap_we), 32'd1);
    check_eq("t1_c1_d", b_o_otfmap_d, 32'h04030201);
    check_eq("t1_c1_run", 32'(o_run), 32'd1);
    cyc = 1;
    while (!o_ot_done && cyc < 40) begin @(negedge clk); cyc++; end
    check_eq("t1_lat", cyc, 5);
    check_eq("t1_done_we", 32'(b_o_otfmap_we), 32'd0);
    check_eq("t1_done_run", 32'(o_run), 32'd0);
    @(negedge clk);
    check_eq("t1_w0", mem[0], 32'h04030201);
    check_eq("t1_w1", mem[1], 32'h08070605);
    check_eq("t1_w2", mem[2], 32'hAAAA0A09);
    check_eq("t1_w3", mem[3], 32'hAAAAAAAA);
    check_eq("t1_rd", rd_cnt - rd0, 1);
    check_eq("t1_wr", wr_cnt - wr0, 3);

    // start=7: partial first and last words
    do_preset();
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(7'd7, mk_data(8'h01), cyc);
    check_eq("t2_lat", cyc, 7);
    @(negedge clk);
    check_eq("t2_w0", mem[0], 32'hAAAAAAAA);
    check_eq("t2_w1", mem[1], 32'h01AAAAAA);
    check_eq("t2_w2", mem[2], 32'h05040302);
    check_eq("t2_w3", mem[3], 32'h09080706);
    check_eq("t2_w4", mem[4], 32'hAAAAAA0A);
    check_eq("t2_w5", mem[5], 32'hAAAAAAAA);
    check_eq("t2_rd", rd_cnt - rd0, 2);
    check_eq("t2_wr", wr_cnt - wr0, 4);

    // start=110: last legal chunk
    do_preset();
    rd0 = rd_cnt; wr0 = wr_cnt; a30 = acc_cnt[30];
    run_op(7'd110, mk_data(8'h01), cyc);
    check_eq("t3_lat", cyc, 5);
    @(negedge clk);
    check_eq("t3_w26", mem[26], 32'hAAAAAAAA);
    check_eq("t3_w27", mem[27], 32'h0201AAAA);
    check_eq("t3_w28", mem[28], 32'h06050403);
    check_eq("t3_w29", mem[29], 32'h0A090807);
    check_eq("t3_acc30", acc_cnt[30] - a30, 0);
    check_eq("t3_rd", rd_cnt - rd0, 1);
    check_eq("t3_wr", wr_cnt - wr0, 3);
    check_eq("t3_err", 32'(o_en_err), 32'd0);

    // start=111: out of range
    wr0 = wr_cnt;
    @(negedge clk);
    i_run = 1'b1; i_wr_start_idx = 7'd111; i_otfmap = mk_data(8'h50);
    @(negedge clk);
    i_run = 1'b0;
    run_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_run) run_seen = 1'b1;
      @(negedge clk);
    end
    check_eq("t4_err", 32'(o_en_err), 32'd1);
    check_eq("t4_run", 32'(run_seen), 32'd0);
    check_eq("t4_wr", wr_cnt - wr0, 0);

    // i_run during an active write is flagged and ignored
    do_reset();
    check_eq("t5_err_clr", 32'(o_en_err), 32'd0);
    do_preset();
    a10 = acc_cnt[10];
    @(negedge clk);
    i_run = 1'b1; i_wr_start_idx = 7'd0; i_otfmap = mk_data(8'h21);
    @(negedge clk);
    i_run = 1'b0;
    @(negedge clk);
    i_run = 1'b1; i_wr_start_idx = 7'd40; i_otfmap = mk_data(8'hF0);
    @(negedge clk);
    i_run = 1'b0;
    cyc = 3;
    while (!o_ot_done && cyc < 40) begin @(negedge clk); cyc++; end
    check_eq("t5_lat", cyc, 5);
    check_eq("t5_err", 32'(o_en_err), 32'd1);
    @(negedge clk);
    check_eq("t5_w0", mem[0], 32'h24232221);
    check_eq("t5_w1", mem[1], 32'h28272625);
    check_eq("t5_w2", mem[2], 32'hAAAA2A29);
    check_eq("t5_acc10", acc_cnt[10] - a10, 0);

    // reset during a write cycle aborts without a done pulse
    do_reset();
    do_preset();
    dn0 = done_cnt;
    @(negedge clk);
    i_run = 1'b1; i_wr_start_idx = 7'd0; i_otfmap = mk_data(8'h31);
    @(negedge clk);
    i_run = 1'b0;
    check_eq("t6_in_wr", 32'(b_o_otfmap_we), 32'd1);
    areset = 1'b1;
    @(negedge clk);
    check_eq("t6_we", 32'(b_o_otfmap_we), 32'd0);
    check_eq("t6_ce", 32'(b_o_otfmap_ce), 32'd0);
    check_eq("t6_idle", 32'(o_idle), 32'd1);
    areset = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t6_nodone", done_cnt - dn0, 0);
    check_eq("t6_w1", mem[1], 32'hAAAAAAAA);

    // normal operation afterwards
    do_preset();
    run_op(7'd7, mk_data(8'h11), cyc);
    check_eq("t7_lat", cyc, 7);
    @(negedge clk);
    check_eq("t7_w1", mem[1], 32'h11AAAAAA);
    check_eq("t7_w2", mem[2], 32'h15141312);
    check_eq("t7_w3", mem[3], 32'h19181716);
    check_eq("t7_w4", mem[4], 32'hAAAAAA1A);
    check_eq("t7_err", 32'(o_en_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
